layer_seq: RTL and testbench
============================

LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 Parameter NEURONS, default 10, number of neurons in the layer.
REQ-002 Parameter INPUTS, default 784, dot-product length per neuron.
REQ-003 Parameter TIMEOUT, default 8192, maximum cycles to wait for MAC completion.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 go  input  1  one-cycle start request for a full layer pass.
REQ-007 mac_run  output  1  run level to the MAC; 0 loads start, 1 computes.
REQ-008 mac_clear  output  1  one-cycle pulse zeroing the MAC accumulator.
REQ-009 mac_start  output  32  signed weight base address for the current neuron.
REQ-010 mac_size  output  32  signed dot-product length.
REQ-011 mac_done  input  1  MAC completion flag.
REQ-012 mac_out  input  16  MAC sum, Q12 sign-magnitude (bit 15 = sign).
REQ-013 wr_en  output  1  one-cycle write strobe to the layer output buffer.
REQ-014 wr_addr  output  16  neuron index being written.
REQ-015 wr_data  output  16  activated neuron value.
REQ-016 busy  output  1  high from go acceptance until DONE or ERR exit.
REQ-017 layer_done  output  1  one-cycle pulse after the last neuron is written.
REQ-018 error  output  1  sticky timeout flag; cleared by reset or an accepted go.

Function
REQ-019 FSM states: IDLE, CLEAR, LOAD, RUN, CAPTURE, NEXT, DONE.
REQ-020 IDLE: go=1 -> CLEAR; neuron index n=0; error cleared; busy=1 on the next cycle.
REQ-021 go SHALL be ignored in every state other than IDLE.
REQ-022 CLEAR, 1 cycle: mac_clear=1, mac_run=0 -> LOAD.
REQ-023 LOAD, 1 cycle: mac_run=0, mac_start=n*INPUTS, mac_size=INPUTS -> RUN.
REQ-024 mac_start and mac_size SHALL hold stable from LOAD through CAPTURE.
REQ-025 RUN: mac_run=1; watchdog counter increments each cycle from 0.
REQ-026 RUN exits to CAPTURE on the first cycle mac_done=1.
REQ-027 RUN with watchdog = TIMEOUT-1 and mac_done=0: error=1, mac_run=0, busy=0 -> IDLE; no write.
REQ-028 mac_done and timeout in the same cycle: mac_done wins -> CAPTURE.
REQ-029 CAPTURE, 1 cycle: wr_en=1, wr_addr=n, wr_data=ReLU(mac_out), mac_run=1 -> NEXT.
REQ-030 ReLU: mac_out[15]=1 (including negative zero 0x8000) -> 0x0000; otherwise mac_out unchanged.
REQ-031 NEXT: mac_run=0; n=NEURONS-1 -> DONE; otherwise n=n+1 -> CLEAR.
REQ-032 DONE, 1 cycle: layer_done=1, busy=0 -> IDLE.
REQ-033 Latency per neuron = 4 + RUN cycles; total = NEURONS*(4+RUN) + 1 cycles from go to layer_done.
REQ-034 n*INPUTS SHALL be computed in 32-bit unsigned arithmetic; no overflow occurs at the default parameters.
REQ-035 wr_en and layer_done SHALL never both be high in the same cycle.
REQ-036 wr_en SHALL be asserted at most once per neuron.

Reset
REQ-037 reset=1 forces state IDLE, n=0, and watchdog=0.
REQ-038 reset=1 drives every output to 0: mac_run, mac_clear, mac_start, mac_size, wr_en, wr_addr, wr_data, busy, layer_done, error.
REQ-039 reset asserted mid-pass aborts the pass; the next cycle shows IDLE with no wr_en and no layer_done pulse.
REQ-040 reset has priority over go in the same cycle.

Verification
REQ-041 NEURONS=3, INPUTS=4, MAC model asserts done after 16 run cycles and returns 0x1000, 0x9000, 0x0800 -> wr_data 0x1000, 0x0000, 0x0800 at wr_addr 0,1,2; layer_done pulses exactly once.
REQ-042 Same setup -> mac_start = 0, 4, 8 in successive LOAD cycles; mac_size = 4 throughout.
REQ-043 MAC never asserts done, TIMEOUT=32 -> error=1 and busy=0 exactly 32 RUN cycles after run rises; wr_en never asserted.
REQ-044 go pulsed again while busy=1 -> no restart; write sequence identical to REQ-041.
REQ-045 reset asserted during RUN of neuron 1 -> next cycle all outputs 0 and IDLE; a following go restarts at wr_addr 0.
REQ-046 mac_done=1 on the same cycle the watchdog expires -> CAPTURE taken; error stays 0.

Source files
------------

// File: rtl/layer_seq_if.sv
// Bundles the sequencer's start request, MAC control/result and output-buffer write port.
// master = the sequencer; slave = the surrounding MAC / buffer / controller side.
interface layer_seq_if;
   logic               go;
   logic               mac_run;
   logic               mac_clear;
   logic signed [31:0] mac_start;
   logic signed [31:0] mac_size;
   logic               mac_done;
   logic [15:0]        mac_out;
   logic               wr_en;
   logic [15:0]        wr_addr;
   logic [15:0]        wr_data;
   logic               busy;
   logic               layer_done;
   logic               error;

   modport master (
      input  go, mac_done, mac_out,
      output mac_run, mac_clear, mac_start, mac_size,
             wr_en, wr_addr, wr_data, busy, layer_done, error
   );

   modport slave (
      output go, mac_done, mac_out,
      input  mac_run, mac_clear, mac_start, mac_size,
             wr_en, wr_addr, wr_data, busy, layer_done, error
   );
endinterface

// File: rtl/layer_seq.sv
// Steps one MAC through every neuron of a layer, ReLU-ing and writing each result.
// Per neuron 4 + RUN cycles; no backpressure, the MAC's done flag paces it, a watchdog bounds each wait.
module layer_seq #(
   parameter int NEURONS = 10,
   parameter int INPUTS  = 784,
   parameter int TIMEOUT = 8192
) (
   input  logic         clk,
   input  logic         reset,
   layer_seq_if.master  bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, CAPTURE, NEXT, DONE} state_t;

   localparam logic [31:0] INPUTS_W = 32'(INPUTS);
   localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 1);
   localparam logic [15:0] N_LAST   = 16'(NEURONS - 1);

   state_t             state_q;
   logic [15:0]        n_q;
   logic [31:0]        wd_q;
   logic               mac_run_q, mac_clear_q, wr_en_q, busy_q, layer_done_q, error_q;
   logic signed [31:0] mac_start_q, mac_size_q;
   logic [15:0]        wr_addr_q, wr_data_q;

   logic [31:0]        start_d;
   logic [15:0]        relu_d;

   // Unsigned 32-bit product keeps the weight base well-defined for any neuron index.
   assign start_d = {16'd0, n_q} * INPUTS_W;
   assign relu_d  = bus.mac_out[15] ? 16'h0000 : bus.mac_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         n_q           <= '0;
         wd_q          <= '0;
         mac_run_q     <= 1'b0;
         mac_clear_q   <= 1'b0;
         mac_start_q   <= '0;
         mac_size_q    <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         busy_q        <= 1'b0;
         layer_done_q  <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         mac_clear_q  <= 1'b0;
         wr_en_q      <= 1'b0;
         layer_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.go) begin
                  state_q     <= CLEAR;
                  n_q         <= '0;
                  error_q     <= 1'b0;
                  busy_q      <= 1'b1;
                  mac_clear_q <= 1'b1;
                  mac_run_q   <= 1'b0;
               end
            end
            CLEAR: begin
               state_q     <= LOAD;
               mac_run_q   <= 1'b0;
               mac_start_q <= $signed(start_d);
               mac_size_q  <= $signed(INPUTS_W);
            end
            LOAD: begin
               state_q   <= RUN;
               mac_run_q <= 1'b1;
               wd_q      <= '0;
            end
            RUN: begin
               // A done arriving on the last watchdog cycle still counts as success.
               if (bus.mac_done) begin
                  state_q   <= CAPTURE;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= n_q;
                  wr_data_q <= relu_d;
               end else if (wd_q == WD_LAST) begin
                  state_q   <= IDLE;
                  error_q   <= 1'b1;
                  busy_q    <= 1'b0;
                  mac_run_q <= 1'b0;
               end else begin
                  wd_q <= wd_q + 32'd1;
               end
            end
            CAPTURE: begin
               state_q   <= NEXT;
               mac_run_q <= 1'b0;
            end
            NEXT: begin
               if (n_q == N_LAST) begin
                  state_q      <= DONE;
                  layer_done_q <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  state_q     <= CLEAR;
                  n_q         <= n_q + 16'd1;
                  mac_clear_q <= 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mac_run    = mac_run_q;
   assign bus.mac_clear  = mac_clear_q;
   assign bus.mac_start  = mac_start_q;
   assign bus.mac_size   = mac_size_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.busy       = busy_q;
   assign bus.layer_done = layer_done_q;
   assign bus.error      = error_q;
endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq with a 3-neuron, 4-input layer and a behavioural MAC.
module tb_layer_seq;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   layer_seq_if bus ();

   layer_seq #(.NEURONS(3), .INPUTS(4), .TIMEOUT(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural MAC: raises done after done_after run cycles (0 = never).
   logic [15:0] vals [3];
   int done_after = 16;
   int run_cnt = 0;
   int mi;
   always @(negedge clk) begin
      if (bus.mac_run && !bus.wr_en) run_cnt = run_cnt + 1;
      else run_cnt = 0;
      bus.mac_done = (done_after != 0) && (run_cnt == done_after);
      mi = bus.mac_start;
      bus.mac_out = (mi >= 0 && mi < 12) ? vals[mi / 4] : 16'h0000;
   end

   int nwr, ndone, done_cyc, both, nld, size_bad, run_rise, err_cyc, bound_hit;
   logic [15:0] wa [8];
   logic [15:0] wdat [8];
   logic [31:0] ls [8];
   logic prev_clear;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses go, then observes until busy drops; cycle 1 is the first cycle after acceptance.
   task automatic run_pass(input int regs_at, input int rst_at, input int max_cyc);
      nwr = 0; ndone = 0; done_cyc = -1; both = 0; nld = 0; size_bad = 0;
      run_rise = -1; err_cyc = -1; bound_hit = 0; prev_clear = 1'b0;
      @(negedge clk);
      bus.go = 1'b1;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clk);
         if (bus.wr_en) begin
            if (nwr < 8) begin
               wa[nwr]   = bus.wr_addr;
               wdat[nwr] = bus.wr_data;
            end
            nwr++;
         end
         if (bus.layer_done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (bus.wr_en && bus.layer_done) both++;
         if (prev_clear) begin
            if (nld < 8) ls[nld] = bus.mac_start;
            nld++;
         end
         if (bus.busy && !bus.mac_clear && bus.mac_size !== 32'sd4) size_bad++;
         prev_clear = bus.mac_clear;
         if (bus.mac_run && run_rise < 0) run_rise = cyc;
         if (bus.error && err_cyc < 0) err_cyc = cyc;
         bus.go = (cyc == regs_at);
         reset  = (cyc == rst_at);
         if (!bus.busy) break;
         if (cyc == max_cyc) bound_hit = 1;
      end
      bus.go = 1'b0;
      reset  = 1'b0;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_ctl"}, {26'd0, bus.mac_run, bus.mac_clear, bus.wr_en, bus.busy,
                          bus.layer_done, bus.error}, 32'd0);
      chk({tag, "_start"}, bus.mac_start, 32'd0);
      chk({tag, "_size"}, bus.mac_size, 32'd0);
      chk({tag, "_wr"}, {bus.wr_addr, bus.wr_data}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.go = 1'b0;
      vals[0] = 16'h1000; vals[1] = 16'h9000; vals[2] = 16'h0800;
      repeat (3) @(negedge clk);
      // go together with reset must be ignored
      bus.go = 1'b1;
      @(negedge clk);
      chk_idle_zero("reset");
      bus.go = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", bus.busy, 32'd0);

      // Nominal layer pass
      run_pass(0, 0, 200);
      chk("p1_bound", bound_hit, 0);
      chk("p1_nwr", nwr, 3);
      chk("p1_addr0", wa[0], 16'd0);
      chk("p1_addr1", wa[1], 16'd1);
      chk("p1_addr2", wa[2], 16'd2);
      chk("p1_data0", wdat[0], 16'h1000);
      chk("p1_data1", wdat[1], 16'h0000);
      chk("p1_data2", wdat[2], 16'h0800);
      chk("p1_ndone", ndone, 1);
      chk("p1_latency", done_cyc, 61);
      chk("p1_overlap", both, 0);
      chk("p1_nload", nld, 3);
      chk("p1_start0", ls[0], 32'd0);
      chk("p1_start1", ls[1], 32'd4);
      chk("p1_start2", ls[2], 32'd8);
      chk("p1_size", size_bad, 0);
      chk("p1_error", bus.error, 1'b0);

      // ReLU edges: negative zero, max positive, all-ones
      vals[0] = 16'h8000; vals[1] = 16'h7FFF; vals[2] = 16'hFFFF;
      run_pass(0, 0, 200);
      chk("relu_nwr", nwr, 3);
      chk("relu_negzero", wdat[0], 16'h0000);
      chk("relu_maxpos", wdat[1], 16'h7FFF);
      chk("relu_allones", wdat[2], 16'h0000);
      vals[0] = 16'h1000; vals[1] = 16'h9000; vals[2] = 16'h0800;

      // go while busy is ignored
      run_pass(10, 0, 200);
      chk("rego_nwr", nwr, 3);
      chk("rego_addr", {wa[0], wa[1], wa[2]}, {16'd0, 16'd1, 16'd2});
      chk("rego_data", {wdat[0], wdat[1], wdat[2]}, {16'h1000, 16'h0000, 16'h0800});
      chk("rego_latency", done_cyc, 61);
      chk("rego_ndone", ndone, 1);
      @(negedge clk);
      chk("rego_no_restart", bus.busy, 1'b0);

      // Watchdog timeout
      done_after = 0;
      run_pass(0, 0, 200);
      chk("to_bound", bound_hit, 0);
      chk("to_run_rise", run_rise, 3);
      chk("to_span", err_cyc - run_rise, 32);
      chk("to_nwr", nwr, 0);
      chk("to_ndone", ndone, 0);
      chk("to_flags", {bus.error, bus.busy, bus.mac_run}, 3'b100);
      repeat (3) @(negedge clk);
      chk("to_sticky", bus.error, 1'b1);

      // Accepted go clears the sticky error
      done_after = 16;
      run_pass(0, 0, 200);
      chk("clr_err_seen", err_cyc, -1);
      chk("clr_nwr", nwr, 3);
      chk("clr_latency", done_cyc, 61);

      // Reset during RUN of neuron 1, then restart
      run_pass(0, 30, 200);
      chk_idle_zero("midrst");
      chk("midrst_nwr", nwr, 1);
      chk("midrst_ndone", ndone, 0);
      run_pass(0, 0, 200);
      chk("restart_nwr", nwr, 3);
      chk("restart_addr0", wa[0], 16'd0);
      chk("restart_latency", done_cyc, 61);

      // done on the very cycle the watchdog expires
      done_after = 32;
      run_pass(0, 0, 300);
      chk("edge_bound", bound_hit, 0);
      chk("edge_nwr", nwr, 3);
      chk("edge_err_seen", err_cyc, -1);
      chk("edge_latency", done_cyc, 109);
      chk("edge_data1", wdat[1], 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
